rom_burst_reader: RTL and testbench

//  Sequences bursts of reads from the synchronous-read ROM block. The ROM has a 1-cycle read latency and no enable.
//  On a start command the block walks base_addr.. for burst_len words. It streams the words out on a valid/ready

---
 rtl/rom_burst_reader.sv | 153 +++++++++++++++
 tb/tb_rom_burst_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Burst sequencer for a 1-cycle-latency synchronous ROM, streaming words out on valid/ready through a 4-entry buffer.
// Optional feature: define CHECKSUM_EN to add a running XOR checksum output of the beats delivered in the current burst.
module rom_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] base_addr,
    input  logic [DEPTH_LOG:0]   burst_len,
    output logic                 busy,
    output logic                 done,
    output logic [DEPTH_LOG-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]     checksum
`endif
);

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state;
    logic [DEPTH_LOG:0]   remaining;
    logic                 vld_p1;
    logic                 vld_p2;
    logic [WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     pending;
    logic                 credit_ok;
    logic                 push;
    logic                 pop;
    logic                 last_beat;
    logic                 accept;

    function automatic logic [DEPTH_LOG-1:0] next_addr(input logic [DEPTH_LOG-1:0] a);
        if (a == DEPTH_LOG'(DEPTH - 1)) begin
            return '0;
        end
        return a + DEPTH_LOG'(1);
    endfunction

    always_comb begin
        out_valid = (fifo_count != '0);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        push      = vld_p2;
        pop       = out_valid && out_ready;
        // Words already buffered plus those still travelling through the ROM must fit the buffer.
        pending   = fifo_count + CNT_W'(vld_p1) + CNT_W'(vld_p2);
        credit_ok = (pending < CNT_W'(FIFO_DEPTH));
        last_beat = pop && (fifo_count == CNT_W'(1)) && !vld_p1 && !vld_p2;
        accept    = (state == IDLE) && start && !done;
    end

    // Stage p1: address register; stage p2: ROM output register; then the buffer write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_addr  <= '0;
            remaining <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= vld_p1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (burst_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            rom_addr  <= base_addr;
                            vld_p1    <= 1'b1;
                            remaining <= burst_len - (DEPTH_LOG + 1)'(1);
                            busy      <= 1'b1;
                            state     <= (burst_len == (DEPTH_LOG + 1)'(1)) ? DRAIN : READ;
                        end
                    end
                end
                READ: begin
                    // remaining counts addresses still to issue after the one in rom_addr.
                    if (credit_ok) begin
                        rom_addr  <= next_addr(rom_addr);
                        vld_p1    <= 1'b1;
                        remaining <= remaining - (DEPTH_LOG + 1)'(1);
                        if (remaining == (DEPTH_LOG + 1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rom_data;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: table-driven bursts, hand-written corner sequences and random bursts
// scored against a queue model of the expected word stream.
module tb_rom_burst_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      burst_len;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rom_mem [DEPTH];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    rom_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    typedef struct {
        int             base;
        int             len;
        int             mode;
        logic [7:0]     first;
        logic [7:0]     last;
    } vec_t;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       exp_q[$];
    int               beats;
    int               done_seen;
    logic [7:0]       first_beat;
    logic [7:0]       last_beat;
    logic             stall_hold;
    logic [7:0]       held_data;
    int               max_fill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples the current cycle (inputs already applied), then advances one clock edge.
    task automatic tick();
        if (stall_hold) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held_data);
        end
        stall_hold = out_valid && !out_ready && !rst;
        held_data  = out_data;
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", out_data, 32'hFFFF_FFFF);
            end else begin
                chk("beat_data", out_data, exp_q.pop_front());
            end
            if (beats == 0) first_beat = out_data;
            last_beat = out_data;
            beats++;
        end
        @(posedge clk);
        #1;
        if (done) done_seen++;
        if (int'(dut.fifo_count) > max_fill) max_fill = int'(dut.fifo_count);
    endtask

    task automatic start_burst(input int b, input int l);
        base_addr = AW'(b);
        burst_len = (AW + 1)'(l);
        start     = 1'b1;
        if (!busy && !done) begin
            for (int i = 0; i < l; i++) exp_q.push_back(rom_mem[(b + i) % DEPTH]);
            beats     = 0;
            done_seen = 0;
        end
        tick();
        start = 1'b0;
    endtask

    function automatic logic ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc >= 10 && cyc < 15) ? 1'b0 : (cyc % 2 == 0);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic finish_burst(input int mode, input int len, input string tag);
        bit fin = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            out_ready = ready_pat(mode, cyc);
            tick();
            if (done) fin = 1;
        end
        chk({tag, "_timeout"}, fin, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_beat_count"}, beats, len);
        out_ready = 1'b1;
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_done_once"}, done_seen, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   got2;
        vecs[0] = '{3, 4, 0, 8'h33, 8'h66};
        vecs[1] = '{14, 4, 0, 8'hEE, 8'h11};
        vecs[2] = '{0, 16, 1, 8'h00, 8'hFF};
        vecs[3] = '{9, 1, 0, 8'h99, 8'h99};
        vecs[4] = '{15, 17, 2, 8'hFF, 8'hFF};
        vecs[5] = '{7, 31, 2, 8'h77, 8'h55};
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'(i * 17);

        stall_hold = 0; beats = 0; done_seen = 0; max_fill = 0;
        first_beat = '0; last_beat = '0; held_data = '0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; burst_len = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 1'b0;
        tick();

        // Latency and back-to-back streaming of a short burst.
        out_ready = 1'b1;
        start_burst(3, 4);
        chk("lat_e0_valid", out_valid, 0);
        chk("lat_e0_busy", busy, 1);
        tick();
        chk("lat_e1_valid", out_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", out_data, 8'(8'h33 + 8'h11 * k));
            chk("b2b_busy", busy, 1);
            tick();
        end
        chk("last_busy_fall", busy, 0);
        chk("last_done", done, 1);
        chk("last_valid", out_valid, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("t1_beats", beats, 4);
        chk("t1_done_once", done_seen, 1);

        for (int v = 0; v < 6; v++) begin
            out_ready = 1'b1;
            start_burst(vecs[v].base, vecs[v].len);
            finish_burst(vecs[v].mode, vecs[v].len, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_first", v), first_beat, vecs[v].first);
            chk($sformatf("vec%0d_last", v), last_beat, vecs[v].last);
        end
        chk("fifo_max_le4", max_fill <= 4, 1);

        // Zero-length burst.
        out_ready = 1'b1;
        start_burst(6, 0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_valid", out_valid, 0);
        tick();
        chk("len0_done_pulse", done, 0);
        chk("len0_valid2", out_valid, 0);

        // Start re-pulse mid-burst is ignored; reset mid-burst discards everything.
        start_burst(0, 8);
        got2 = 0;
        for (int c = 0; c < 20 && !got2; c++) begin
            if (c == 1) begin
                base_addr = 4'd9; burst_len = 5'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (beats >= 2) got2 = 1;
        end
        start = 1'b0;
        chk("two_beats_seen", got2, 1);
        chk("repulse_beat1", first_beat, 8'h00);
        rst = 1'b1; out_ready = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_addr", rom_addr, 0);
        exp_q.delete();
        stall_hold = 0;
        rst = 1'b0;
        tick();
        chk("postrst_valid", out_valid, 0);
        out_ready = 1'b1;
        start_burst(5, 2);
        finish_burst(0, 2, "after_rst");
        chk("after_rst_first", first_beat, 8'h55);
        chk("after_rst_last", last_beat, 8'h66);
        for (int c = 0; c < 4; c++) tick();
        chk("after_rst_quiet", out_valid, 0);

`ifdef CHECKSUM_EN
        start_burst(0, 3);
        finish_burst(0, 3, "cks");
        chk("cks_value", checksum, 8'h33);
        start_burst(2, 1);
        chk("cks_clear", checksum, 8'h00);
        finish_burst(0, 1, "cks2");
        chk("cks2_value", checksum, 8'h22);
`endif

        for (int r = 0; r < 8; r++) begin
            int b;
            int l;
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 2 * DEPTH - 1);
            out_ready = 1'b1;
            start_burst(b, l);
            finish_burst(2, l, $sformatf("rnd%0d", r));
        end
        chk("fifo_max_final", max_fill <= 4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
